// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_cpu
// Description : Multi-cycle 16-bit-encoding core. Instruction and data memories
//               sit behind req/valid and req/ready handshakes.
//               Define MULTICYCLE_CPU_INSTRET_EN to build the retired-instruction
//               counter; otherwise instret is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_cpu #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic [PC_W-1:0]    pc,
    output logic [15:0]        instruction,
    output logic               halted,
    output logic [31:0]        instret,
    input  logic [2:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_ALU  = 3'b001;
    localparam logic [2:0] c_OP_HALT = 3'b010;
    localparam logic [2:0] c_OP_ADDI = 3'b011;
    localparam logic [2:0] c_OP_LD   = 3'b100;
    localparam logic [2:0] c_OP_ST   = 3'b101;
    localparam logic [2:0] c_OP_BEQ  = 3'b110;
    localparam logic [2:0] c_OP_JMP  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_instr;
    logic [DATA_W-1:0]   r_regs [8];
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [DATA_W-1:0]   r_result;
    logic [DADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [2:0]          w_op;
    logic [2:0]          w_rs;
    logic [2:0]          w_rt;
    logic [2:0]          w_rd;
    logic [3:0]          w_func;
    logic [2:0]          w_wb_idx;
    logic [DATA_W-1:0]   w_imm_d;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_ok;
    logic [PC_W-1:0]     w_imm_pc;
    logic [PC_W-1:0]     w_jmp_pc;
    logic [PC_W-1:0]     w_pc_inc;
    logic [DADDR_W-1:0]  w_ea;

    assign w_op     = r_instr[15:13];
    assign w_rs     = r_instr[12:10];
    assign w_rt     = r_instr[9:7];
    assign w_rd     = r_instr[6:4];
    assign w_func   = r_instr[3:0];
    assign w_wb_idx = (w_op == c_OP_ALU) ? w_rd : w_rt;
    assign w_imm_d  = {{(DATA_W-7){r_instr[6]}}, r_instr[6:0]};
    assign w_sum    = r_op_a + w_imm_d;
    assign w_pc_inc = r_pc + PC_W'(1);

    // Immediates and the effective address are resized to whatever widths the
    // instance is built with; narrow targets simply keep the low bits.
    generate
        if (PC_W > 7) begin : g_pc_imm_wide
            assign w_imm_pc = {{(PC_W-7){r_instr[6]}}, r_instr[6:0]};
        end else begin : g_pc_imm_narrow
            assign w_imm_pc = r_instr[PC_W-1:0];
        end
        if (PC_W > 13) begin : g_jmp_wide
            assign w_jmp_pc = {{(PC_W-13){1'b0}}, r_instr[12:0]};
        end else begin : g_jmp_narrow
            assign w_jmp_pc = r_instr[PC_W-1:0];
        end
        if (DADDR_W > DATA_W) begin : g_ea_wide
            assign w_ea = {{(DADDR_W-DATA_W){1'b0}}, w_sum};
        end else begin : g_ea_narrow
            assign w_ea = w_sum[DADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        w_alu_ok  = 1'b1;
        w_alu_res = '0;
        case (w_func)
            4'd0:    w_alu_res = r_op_a + r_op_b;
            4'd1:    w_alu_res = r_op_a & r_op_b;
            4'd2:    w_alu_res = ~r_op_a + r_op_b;
            4'd3:    w_alu_res = r_op_a - r_op_b;
            default: w_alu_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_instr  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_instr <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op_a  <= r_regs[w_rs];
                    r_op_b  <= r_regs[w_rt];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_ALU: begin
                            if (w_alu_ok) begin
                                r_result <= w_alu_res;
                                r_state  <= S_WB;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_FETCH;
                            end
                        end
                        c_OP_ADDI: begin
                            r_result <= w_sum;
                            r_state  <= S_WB;
                        end
                        c_OP_LD, c_OP_ST: begin
                            r_addr  <= w_ea;
                            r_wdata <= r_op_b;
                            r_state <= S_MEM;
                        end
                        c_OP_BEQ: begin
                            r_pc    <= (r_op_a == r_op_b) ? (r_pc + w_imm_pc) : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        c_OP_JMP: begin
                            r_pc    <= w_jmp_pc;
                            r_state <= S_FETCH;
                        end
                        c_OP_HALT: begin
                            r_state <= S_HALT;
                        end
                        default: begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == c_OP_LD) begin
                            r_result <= dmem_rdata;
                            r_state  <= S_WB;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    // r0 is never written, so it keeps its reset value of zero.
                    if (w_wb_idx != 3'd0) begin
                        r_regs[w_wb_idx] <= r_result;
                    end
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Requests are gated with reset so they drop in the cycle reset rises.
    assign imem_req    = (r_state == S_FETCH) && !reset;
    assign imem_addr   = r_pc;
    assign dmem_req    = (r_state == S_MEM) && !reset;
    assign dmem_we     = (w_op == c_OP_ST);
    assign dmem_addr   = r_addr;
    assign dmem_wdata  = r_wdata;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign halted      = (r_state == S_HALT);
    assign dbg_data    = r_regs[dbg_addr];

`ifdef MULTICYCLE_CPU_INSTRET_EN
    logic        w_retire;
    logic [31:0] r_instret;

    assign w_retire = (r_state == S_WB)
                   || ((r_state == S_MEM) && dmem_ready && (w_op == c_OP_ST))
                   || ((r_state == S_EXEC) && ((w_op == c_OP_BEQ) || (w_op == c_OP_JMP)
                       || (w_op == c_OP_NOP) || ((w_op == c_OP_ALU) && !w_alu_ok)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_cpu
// Description : Directed and random-program bench for multicycle_cpu with an
//               ISA-level reference interpreter and wait-state memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_cpu;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int AW = 4;
`ifdef MULTICYCLE_CPU_INSTRET_EN
    localparam logic [31:0] IR_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] IR_MASK = 32'h0;
`endif
    localparam logic [15:0] HALT = 16'h4000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_valid = 1'b0;
    logic [15:0]   imem_rdata = '0;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;
    logic          dmem_ready = 1'b0;
    logic [PW-1:0] pc;
    logic [15:0]   instruction;
    logic          halted;
    logic [31:0]   instret;
    logic [2:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    always #5 clock = ~clock;

    multicycle_cpu #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc(pc), .instruction(instruction), .halted(halted), .instret(instret),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    logic [15:0]   imem [16];
    logic [DW-1:0] dmem [16];
    int errors = 0;
    int checks = 0;

    // memory responder state
    bit            i_pend, d_pend, rand_w, spur;
    int            i_left, d_left, i_max, d_max;
    int            i_waits = 0, d_waits = 0, d_unstable = 0;
    logic          d_we0;
    logic [AW-1:0] d_a0, st_a;
    logic [DW-1:0] d_w0, st_d;

    // reference model state
    logic [DW-1:0] m_reg [8];
    logic [DW-1:0] m_mem [16];
    logic [PW-1:0] m_pc;
    int            m_cycles, m_retired;

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [3:0] fn);
        return {3'b001, rs, rt, rd, fn};
    endfunction
    function automatic logic [15:0] enc_j(input logic [12:0] t);
        return {3'b111, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pickw(input int mx);
        return rand_w ? int'($urandom_range(0, mx)) : mx;
    endfunction

    task automatic respond();
        if (imem_req) begin
            if (!i_pend) begin i_pend = 1; i_left = pickw(i_max); end
            if (i_left > 0) begin
                imem_valid = 1'b0; imem_rdata = 16'($urandom); i_left--; i_waits++;
            end else begin
                imem_valid = 1'b1; imem_rdata = imem[imem_addr]; i_pend = 0;
            end
        end else begin
            i_pend = 0;
            imem_valid = spur ? 1'($urandom) : 1'b0;
            imem_rdata = 16'($urandom);
        end
        if (dmem_req) begin
            if (!d_pend) begin
                d_pend = 1; d_left = pickw(d_max);
                d_we0 = dmem_we; d_a0 = dmem_addr; d_w0 = dmem_wdata;
            end else if ({dmem_we, dmem_addr, dmem_wdata} !== {d_we0, d_a0, d_w0}) begin
                d_unstable++;
            end
            if (d_left > 0) begin
                dmem_ready = 1'b0; dmem_rdata = DW'($urandom); d_left--; d_waits++;
            end else begin
                dmem_ready = 1'b1; d_pend = 0;
                if (dmem_we) begin
                    dmem[dmem_addr] = dmem_wdata; st_a = dmem_addr; st_d = dmem_wdata;
                end else begin
                    dmem_rdata = dmem[dmem_addr];
                end
            end
        end else begin
            d_pend = 0;
            dmem_ready = spur ? 1'($urandom) : 1'b0;
            dmem_rdata = DW'($urandom);
        end
    endtask

    // Every clock step goes through here so stimulus and memories share one process.
    task automatic tick();
        @(negedge clock);
        respond();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic check_reg(input string tag, input logic [2:0] r, input logic [DW-1:0] exp);
        dbg_addr = r;
        #1;
        check(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic wr(input logic [2:0] idx, input logic [DW-1:0] v);
        if (idx != 3'd0) m_reg[idx] = v;
    endtask

    // Architectural interpreter: one instruction per iteration, plus cycle cost.
    task automatic model_run();
        logic [15:0]   ins;
        logic [2:0]    op, rs, rt, rd;
        logic [3:0]    fn;
        logic [DW-1:0] a, b, imm, ea, r;
        m_cycles  = 3;
        m_retired = 0;
        for (int n = 0; n < 64; n++) begin
            ins = imem[m_pc];
            op = ins[15:13]; rs = ins[12:10]; rt = ins[9:7]; rd = ins[6:4]; fn = ins[3:0];
            a = m_reg[rs]; b = m_reg[rt]; imm = {ins[6], ins[6:0]};
            ea = a + imm;
            if (op == 3'b010) break;
            m_retired++;
            case (op)
                3'b001: begin
                    if (fn < 4) begin
                        case (fn)
                            4'd0:    r = a + b;
                            4'd1:    r = a & b;
                            4'd2:    r = ~a + b;
                            default: r = a - b;
                        endcase
                        wr(rd, r);
                        m_cycles += 4;
                    end else begin
                        m_cycles += 3;
                    end
                    m_pc = m_pc + 4'd1;
                end
                3'b011: begin wr(rt, ea); m_cycles += 4; m_pc = m_pc + 4'd1; end
                3'b100: begin wr(rt, m_mem[ea[3:0]]); m_cycles += 5; m_pc = m_pc + 4'd1; end
                3'b101: begin m_mem[ea[3:0]] = b; m_cycles += 4; m_pc = m_pc + 4'd1; end
                3'b110: begin m_pc = (a == b) ? m_pc + imm[3:0] : m_pc + 4'd1; m_cycles += 3; end
                3'b111: begin m_pc = ins[3:0]; m_cycles += 3; end
                default: begin m_pc = m_pc + 4'd1; m_cycles += 3; end
            endcase
        end
    endtask

    initial begin
        int cyc, wi0, wd0, du0, k;
        bit req_seen;
        rand_w = 0; spur = 0; i_max = 0; d_max = 0;
        for (int i = 0; i < 16; i++) dmem[i] = '0;

        // Reset state, then the three-instruction add program.
        clear_imem();
        imem[0] = enc_i(3'b011, 3'd0, 3'd1, 7'd1);
        imem[1] = enc_i(3'b011, 3'd0, 3'd2, 7'd1);
        imem[2] = enc_r(3'd1, 3'd2, 3'd3, 4'd0);
        imem[3] = HALT;
        reset = 1'b1;
        tick();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        tick();
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_instr", {16'd0, instruction}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_instret", instret, 32'd0);
        reset = 1'b0;
        for (int r = 0; r < 8; r++) check_reg($sformatf("rst_r%0d", r), 3'(r), '0);
        repeat (11) tick();
        check_reg("add_before_wb", 3'd3, 8'd0);
        tick();
        check_reg("add_r3_12cyc", 3'd3, 8'd2);
        check("add_instret", instret, 32'd3 & IR_MASK);

        // Reset while the next fetch is stalled on imem_valid.
        i_max = 50;
        tick();
        tick();
        check("fetch_waiting_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("req_drops_on_reset", {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        i_max = 0;
        check("rerst_pc", {28'd0, pc}, 32'd0);
        check("rerst_instret", instret, 32'd0);
        check("rerst_instr", {16'd0, instruction}, 32'd0);
        for (int r = 1; r < 4; r++) check_reg($sformatf("rerst_r%0d", r), 3'(r), '0);

        // Store then load with two data wait states.
        clear_imem();
        imem[0] = enc_i(3'b011, 3'd0, 3'd1, 7'd1);
        imem[1] = enc_i(3'b011, 3'd0, 3'd2, 7'd1);
        imem[2] = enc_i(3'b101, 3'd1, 3'd2, 7'd3);
        imem[3] = enc_i(3'b100, 3'd1, 3'd3, 7'd3);
        imem[4] = HALT;
        d_max = 2;
        st_a = '0; st_d = '0;
        do_reset();
        du0 = d_unstable;
        repeat (14) tick();
        check("st_addr", {28'd0, st_a}, 32'd4);
        check("st_data", {24'd0, st_d}, 32'd1);
        check("st_mem4", {24'd0, dmem[4]}, 32'd1);
        repeat (6) tick();
        check_reg("ld_before_7cyc", 3'd3, 8'd0);
        tick();
        check_reg("ld_r3_7cyc", 3'd3, 8'd1);
        check("dmem_stable", d_unstable - du0, 32'd0);
        d_max = 0;

        // beq taken / not taken at pc 8.
        for (int eq = 0; eq < 2; eq++) begin
            clear_imem();
            imem[0] = enc_i(3'b011, 3'd0, 3'd2, 7'd5);
            imem[1] = enc_i(3'b011, 3'd0, 3'd3, (eq == 1) ? 7'd5 : 7'd6);
            imem[2] = enc_j(13'd8);
            imem[8] = enc_i(3'b110, 3'd2, 3'd3, 7'd3);
            imem[9] = HALT;
            imem[11] = HALT;
            do_reset();
            run_to_halt(cyc);
            check($sformatf("beq_eq%0d_pc", eq), {28'd0, pc}, (eq == 1) ? 32'd11 : 32'd9);
            check($sformatf("beq_eq%0d_instret", eq), instret, 32'd4 & IR_MASK);
        end

        // pc wrap: beq +1 at pc 15 lands on 0.
        clear_imem();
        imem[0] = enc_j(13'd15);
        imem[15] = enc_i(3'b110, 3'd0, 3'd0, 7'd1);
        do_reset();
        repeat (3) tick();
        check("jmp15_pc", {28'd0, pc}, 32'd15);
        repeat (3) tick();
        check("beq_wrap_pc", {28'd0, pc}, 32'd0);

        // jmp 5, then halt is absorbing even with stray valids.
        clear_imem();
        imem[0] = enc_j(13'd5);
        imem[5] = HALT;
        do_reset();
        repeat (3) tick();
        check("jmp5_pc", {28'd0, pc}, 32'd5);
        repeat (3) tick();
        check("halt_flag", {31'd0, halted}, 32'd1);
        spur = 1;
        req_seen = 0;
        repeat (20) begin
            tick();
            req_seen |= imem_req;
        end
        spur = 0;
        check("halt_no_req", {31'd0, req_seen}, 32'd0);
        check("halt_pc", {28'd0, pc}, 32'd5);
        check("halt_instret", instret, 32'd1 & IR_MASK);

        // r0 discard and 8-bit wrap.
        clear_imem();
        imem[0] = enc_i(3'b011, 3'd0, 3'd0, 7'd7);
        imem[1] = enc_i(3'b011, 3'd0, 3'd1, 7'h7F);
        imem[2] = enc_i(3'b011, 3'd1, 3'd1, 7'd1);
        imem[3] = HALT;
        do_reset();
        repeat (8) tick();
        check_reg("r0_zero", 3'd0, 8'd0);
        check_reg("r1_minus1", 3'd1, 8'hFF);
        run_to_halt(cyc);
        check_reg("r1_wrap", 3'd1, 8'h00);

        // Random forward-only programs with random wait states and stray handshakes.
        for (int p = 0; p < 8; p++) begin
            clear_imem();
            for (int i = 0; i < 15; i++) begin
                k = int'($urandom_range(0, 9));
                case (k)
                    0, 1, 2: imem[i] = enc_r(3'($urandom), 3'($urandom), 3'($urandom),
                                             4'($urandom_range(0, 5)));
                    3, 4:    imem[i] = enc_i(3'b011, 3'($urandom), 3'($urandom), 7'($urandom));
                    5:       imem[i] = enc_i(3'b100, 3'($urandom), 3'($urandom), 7'($urandom));
                    6:       imem[i] = enc_i(3'b101, 3'($urandom), 3'($urandom), 7'($urandom));
                    7:       imem[i] = enc_i(3'b110, 3'($urandom), 3'($urandom),
                                             7'($urandom_range(1, 15 - i)));
                    8:       imem[i] = enc_j(13'($urandom_range(i + 1, 15)));
                    default: imem[i] = 16'h0000;
                endcase
            end
            imem[15] = HALT;
            for (int i = 0; i < 16; i++) begin
                dmem[i]  = DW'($urandom);
                m_mem[i] = dmem[i];
            end
            for (int r = 0; r < 8; r++) m_reg[r] = '0;
            m_pc = '0;
            rand_w = 1; spur = 1;
            i_max = p % 4; d_max = (p + 1) % 4;
            do_reset();
            wi0 = i_waits; wd0 = d_waits; du0 = d_unstable;
            run_to_halt(cyc);
            model_run();
            check($sformatf("p%0d_pc", p), {28'd0, pc}, {28'd0, m_pc});
            check($sformatf("p%0d_instret", p), instret, 32'(m_retired) & IR_MASK);
            check($sformatf("p%0d_cycles", p), cyc, m_cycles + (i_waits - wi0) + (d_waits - wd0));
            check($sformatf("p%0d_dmem_stable", p), d_unstable - du0, 32'd0);
            for (int r = 0; r < 8; r++) check_reg($sformatf("p%0d_r%0d", p, r), 3'(r), m_reg[r]);
            for (int i = 0; i < 16; i++)
                check($sformatf("p%0d_mem%0d", p, i), {24'd0, dmem[i]}, {24'd0, m_mem[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_cpu.md
# multicycle_cpu

- Parametrised multi-cycle successor to the team's 16-bit single-cycle core.
- Same 16-bit instruction encoding, with configurable data width and memory address widths.
- Instruction and data memories sit outside the core behind valid/ready-style handshakes, so the core tolerates wait states.
- Sits between the instruction ROM/loader and the data RAM; exposes architectural state for the testbench.

## Interface
- DATA_W, 16: register/ALU/data-memory word width; legal range 8..32.
- PC_W, 8: program counter width; instruction memory holds 2^PC_W words.
- DADDR_W, 8: data memory address width.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled only on rising clock edge.
- imem_req  out  1  fetch request; high only in FETCH and reset low.
- imem_addr  out  PC_W  equals pc.
- imem_valid  in  1  fetch data valid this cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request; high only in MEM.
- dmem_we  out  1  1=store, 0=load; meaningful only while dmem_req high.
- dmem_addr  out  DADDR_W  effective address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data.
- dmem_ready  in  1  access complete this cycle.
- pc  out  PC_W  current pc.
- instruction  out  16  latched instruction.
- halted  out  1  core in HALT.
- instret  out  32  retired-instruction count; see Configuration.
- dbg_addr  in  3  debug register select.
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr].

## Operation
Registers and encoding:
- Eight registers; r0 reads 0 and writes to it are discarded.
- Fields: op[15:13], rs[12:10], rt[9:7], rd[6:4], func[3:0], imm7[6:0], imm13[12:0].
- imm7 is sign-extended to DATA_W.
- op 001 (R-type), result to rd:
  - func 0000 add: rs+rt.
  - func 0001 and: rs&rt.
  - func 0010 not: ~rs+rt.
  - func 0011 sub: rs−rt.
  - Any other func: no-op.
- op 011 addi: rt = rs+imm7.
- op 100 ld: rt = mem[rs+imm7].
- op 101 st: mem[rs+imm7] = rt.
- op 110 beq: if rs==rt then pc = pc+imm7, else pc+1.
- op 111 jmp: pc = imm13[PC_W-1:0].
- op 010 halt.
- op 000 nop.

Arithmetic:
- All arithmetic is modulo 2^DATA_W.
- pc arithmetic is modulo 2^PC_W; wrap-around from max to 0 is required.
- Effective address = (rs+imm7)[DADDR_W-1:0].

FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: hold imem_req until imem_valid. Latch instruction, then go to DECODE.
- DECODE: read rs/rt into operand registers.
- EXEC:
  - ALU/addi: go to WB.
  - ld/st: latch address and store data, then go to MEM.
  - beq/jmp/nop/illegal func: update pc, then go to FETCH.
  - halt: go to HALT with pc unchanged.
- MEM: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ready.
  - ld: latch dmem_rdata, then go to WB.
  - st: pc+1, then go to FETCH.
- WB: write the register, pc+1, then go to FETCH.
- HALT: absorbing state. Only reset leaves it.

## Timing
- Reset state: pc=0, all registers 0, instruction=0, state FETCH, halted=0, instret=0.
- While reset is high, imem_req=0 and dmem_req=0.
- Reset asserted mid-handshake: the request drops in the same cycle. Any in-flight result is discarded.
- A handshake completes in the cycle where req and valid/ready are both high. Zero-wait response is legal.
- Cycles per instruction with zero-wait memories:
  - add/and/not/sub/addi: 4.
  - ld: 5.
  - st: 4.
  - beq/jmp/nop: 3.
- Each wait state adds one cycle.
- imem_valid or dmem_ready arriving outside the matching request is ignored.
- A register write becomes visible on dbg_data in the cycle after WB.
- instret increments in the same edge that leaves WB, MEM(st) or EXEC(branch/jump/nop). It does not increment for halt.

## Configuration
- MULTICYCLE_CPU_INSTRET_EN defined: instret counts retired instructions. It is 32-bit and wraps.
- Undefined: the counter logic is removed and instret is tied to 0.

## Test plan
- Reset, then addi r1,r0,1; addi r2,r0,1; add r3,r1,r2, zero-wait memory -> dbg r3=2 after 12 cycles.
- st r2 to [r1+3], then ld r3 from [r1+3], with dmem_ready delayed 2 cycles -> dmem_addr=4 and dmem_wdata=1 held stable; r3=1; ld takes 7 cycles.
- beq r2,r3,+3 at pc 8 with r2==r3 -> pc 11. Repeat with r2≠r3 -> pc 9. PC_W=4, beq at pc 15 with +1 -> pc 0.
- jmp 5 -> pc 5. halt -> halted=1, imem_req stays 0 for 20 cycles, pc unchanged.
- addi r0,r0,7 -> r0 reads 0. addi r1,r0,-1 with DATA_W=8 -> r1=0xFF; addi r1,r1,1 -> 0x00.
- Reset asserted while imem_req waits on imem_valid -> req low in the same cycle. After release: pc=0, all registers 0, instret=0.
